// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the external 4-bit ALU: owns accumulator, C/Z flags and skip/output control.
// Define ALU_SEQ_TRAP_EN to make an illegal opcode halt the block until reset instead of retiring as a NOP.
module alu_sequencer #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [DATA_W-1:0] instr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_c,
    input  logic              alu_z,
    output logic [DATA_W-1:0] accu,
    output logic              flag_c,
    output logic              flag_z,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_TST  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_SKPZ = 4'h8;
    localparam logic [3:0] OP_SKPC = 4'h9;

    localparam logic [2:0] F_PASS_A = 3'b000;
    localparam logic [2:0] F_SUB    = 3'b001;
    localparam logic [2:0] F_PASS_B = 3'b010;
    localparam logic [2:0] F_ADD    = 3'b011;
    localparam logic [2:0] F_NAND   = 3'b100;

    logic [1:0]        state_q, state_d;
    logic [3:0]        ir_op_q, ir_op_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic [DATA_W-1:0] res_s_q, res_s_d;
    logic              res_c_q, res_c_d;
    logic              res_z_q, res_z_d;
    logic [DATA_W-1:0] accu_q, accu_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              illegal_q, illegal_d;
    logic              skip_q, skip_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halted_w;
    logic [2:0]        exec_f;
    logic              retire;

`ifdef ALU_SEQ_TRAP_EN
    logic halted_q, halted_d;
    assign halted_w = halted_q;
`else
    assign halted_w = 1'b0;
`endif

    always_comb begin
        exec_f = F_PASS_A;
        case (ir_op_q)
            OP_LIT:  exec_f = F_PASS_B;
            OP_CMP:  exec_f = F_SUB;
            OP_ADD:  exec_f = F_ADD;
            OP_NAND: exec_f = F_NAND;
            default: exec_f = F_PASS_A;
        endcase
    end

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        ir_op_d     = ir_op_q;
        ir_data_d   = ir_data_q;
        res_s_d     = res_s_q;
        res_c_d     = res_c_q;
        res_z_d     = res_z_q;
        accu_d      = accu_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        illegal_d   = illegal_q;
        skip_d      = skip_q;
        retired_d   = retired_q;
        retire      = 1'b0;
`ifdef ALU_SEQ_TRAP_EN
        halted_d    = halted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    // A pending skip swallows the offered instruction without leaving IDLE.
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        ir_op_d   = instr_op;
                        ir_data_d = instr_data;
                        state_d   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                res_s_d = alu_s;
                res_c_d = alu_c;
                res_z_d = alu_z;
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                retire  = 1'b1;
                case (ir_op_q)
                    OP_NOP: ;
                    OP_LIT, OP_ADD: begin
                        accu_d   = res_s_q;
                        flag_c_d = res_c_q;
                        flag_z_d = res_z_q;
                    end
                    OP_NAND: begin
                        accu_d   = res_s_q;
                        flag_c_d = 1'b0;
                        flag_z_d = res_z_q;
                    end
                    OP_CMP, OP_TST: begin
                        flag_c_d = res_c_q;
                        flag_z_d = res_z_q;
                    end
                    OP_OUT: begin
                        out_valid_d = 1'b1;
                        out_data_d  = accu_q;
                    end
                    OP_SKPZ: skip_d = flag_z_q;
                    OP_SKPC: skip_d = flag_c_q;
                    default: begin
                        illegal_d = 1'b1;
`ifdef ALU_SEQ_TRAP_EN
                        halted_d  = 1'b1;
                        state_d   = ST_HALT;
                        retire    = 1'b0;
`endif
                    end
                endcase
                if (retire) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ir_op_q     <= OP_NOP;
            ir_data_q   <= '0;
            res_s_q     <= '0;
            res_c_q     <= 1'b0;
            res_z_q     <= 1'b0;
            accu_q      <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            illegal_q   <= 1'b0;
            skip_q      <= 1'b0;
            retired_q   <= '0;
`ifdef ALU_SEQ_TRAP_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            ir_op_q     <= ir_op_d;
            ir_data_q   <= ir_data_d;
            res_s_q     <= res_s_d;
            res_c_q     <= res_c_d;
            res_z_q     <= res_z_d;
            accu_q      <= accu_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            illegal_q   <= illegal_d;
            skip_q      <= skip_d;
            retired_q   <= retired_d;
`ifdef ALU_SEQ_TRAP_EN
            halted_q    <= halted_d;
`endif
        end
    end

    assign instr_ready = (state_q == ST_IDLE) && !halted_w;
    assign busy        = (state_q != ST_IDLE);
    assign alu_a       = accu_q;
    assign alu_b       = ir_data_q;
    assign alu_f       = (state_q == ST_EXEC) ? exec_f : F_PASS_A;
    assign accu        = accu_q;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign illegal     = illegal_q;
    assign halted      = halted_w;
    assign retired     = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random legal instructions against an ISA-level model.
// Builds with or without ALU_SEQ_TRAP_EN; the illegal-opcode scenario adapts to the build.
module tb_alu_sequencer;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [3:0]        instr_op = 4'h0;
    logic [DATA_W-1:0] instr_data = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_s;
    logic [2:0]        alu_f;
    logic              alu_c, alu_z;
    logic [DATA_W-1:0] accu, out_data;
    logic              flag_c, flag_z, out_valid, busy, illegal, halted;
    logic [CNT_W-1:0]  retired;

    int checks = 0;
    int errors = 0;

    // ISA-level reference state
    int m_accu, m_c, m_z, m_skip, m_illegal, m_halted, m_retired;

    alu_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_s(alu_s), .alu_c(alu_c), .alu_z(alu_z),
        .accu(accu), .flag_c(flag_c), .flag_z(flag_z),
        .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .illegal(illegal), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    // External combinational ALU
    always_comb begin
        alu_c = 1'b0;
        case (alu_f)
            3'b001: begin alu_s = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            3'b010: alu_s = alu_b;
            3'b011: {alu_c, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b100: alu_s = ~(alu_a & alu_b);
            default: alu_s = alu_a;
        endcase
        alu_z = (alu_s == 4'h0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_func(input int op);
        case (op)
            1: return 2;
            2: return 1;
            3: return 3;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_accu = 0; m_c = 0; m_z = 0; m_skip = 0;
        m_illegal = 0; m_halted = 0; m_retired = 0;
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Issue one instruction; called on a negedge, returns on the negedge after its effects are visible.
    task automatic send(input int op, input int d);
        int wait_n;
        int sum;
        int old_accu;
        int next_skip;
        wait_n = 0;
        while (!instr_ready && wait_n < 20) begin
            @(negedge clock);
            wait_n++;
        end
        if (wait_n >= 20) begin
            check("ready_timeout", instr_ready, 1);
            finish_now();
        end
        instr_valid = 1'b1;
        instr_op    = 4'(op);
        instr_data  = 4'(d);
        @(negedge clock);
        instr_valid = 1'b0;
        instr_op    = 4'($urandom);
        instr_data  = 4'($urandom);
        if (m_skip != 0) begin
            m_skip = 0;
            check("skip_ready", instr_ready, 1);
            check("skip_busy", busy, 0);
            check("skip_accu", accu, m_accu);
            check("skip_retired", retired, m_retired);
            return;
        end
        old_accu = m_accu;
        check("exec_ready", instr_ready, 0);
        check("exec_busy", busy, 1);
        check("exec_f", alu_f, exp_func(op));
        check("exec_a", alu_a, old_accu);
        check("exec_b", alu_b, d);
        check("exec_outv", out_valid, 0);
        @(negedge clock);
        check("wb_ready", instr_ready, 0);
        check("wb_f", alu_f, 0);
        check("wb_outv", out_valid, 0);

        next_skip = 0;
        case (op)
            0: ;
            1: begin m_accu = d; m_c = 0; m_z = (d == 0); end
            2: begin m_c = (m_accu < d); m_z = (m_accu == d); end
            3: begin sum = m_accu + d; m_accu = sum % 16; m_c = (sum > 15); m_z = (m_accu == 0); end
            4: begin m_accu = 15 - (m_accu & d); m_c = 0; m_z = (m_accu == 0); end
            5: begin m_c = 0; m_z = (m_accu == 0); end
            6: ;
            8: next_skip = m_z;
            9: next_skip = m_c;
            default: begin
                m_illegal = 1;
`ifdef ALU_SEQ_TRAP_EN
                m_halted = 1;
`endif
            end
        endcase
        m_skip = next_skip;
        if (m_halted == 0) m_retired = (m_retired + 1) % (1 << CNT_W);

        @(negedge clock);
        check("accu", accu, m_accu);
        check("flag_c", flag_c, m_c);
        check("flag_z", flag_z, m_z);
        check("retired", retired, m_retired);
        check("illegal", illegal, m_illegal);
        check("halted", halted, m_halted);
        check("ready_back", instr_ready, (m_halted == 0));
        check("out_valid", out_valid, (op == 6));
        if (op == 6) check("out_data", out_data, old_accu);
    endtask

    initial begin
        int legal_ops[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_accu", accu, 0);
        check("rst_retired", retired, 0);
        check("rst_outv", out_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);
        check("rst_alu_f", alu_f, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Scenario 1: LIT/ADD
        send(1, 5); send(3, 3);
        check("t1_accu", accu, 8);
        check("t1_retired", retired, 2);

        // Scenario 2: carry out and borrow
        send(1, 15); send(3, 1);
        check("t2_cz", {flag_c, flag_z}, 2'b11);
        send(2, 5);
        check("t2_cmp", {accu, flag_c, flag_z}, {4'h0, 2'b10});

        // Scenario 3: SKPZ consumes the following instruction
        send(1, 3); send(2, 3); send(8, 0); send(1, 9); send(1, 7);
        check("t3_accu", accu, 7);

        // Scenario 4: NAND to zero, then output strobe
        send(1, 15); send(4, 15); send(6, 0);
        check("t4_out", out_data, 0);
        @(negedge clock);
        check("t4_strobe_once", out_valid, 0);

        // Random legal traffic; long enough to wrap the retired counter
        for (int i = 0; i < 320; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, 15)));
        end

        // Reset in the middle of an ADD
        if (m_skip != 0) send(0, 0);
        send(1, 5);
        instr_valid = 1'b1; instr_op = 4'h3; instr_data = 4'h3;
        @(negedge clock);
        instr_valid = 1'b0;
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_accu", accu, 0);
        check("mid_ready", instr_ready, 1);
        check("mid_retired", retired, 0);
        repeat (2) begin
            @(negedge clock);
            check("mid_outv", out_valid, 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_after_busy", busy, 0);
        check("mid_after_accu", accu, 0);
        send(1, 6); send(3, 9);

        // Illegal opcode
        send(11, 4);
`ifdef ALU_SEQ_TRAP_EN
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            check("halt_ready", instr_ready, 0);
            check("halt_busy", busy, 1);
        end
`else
        send(3, 1);
        check("illegal_sticky", illegal, 1);
`endif
        reset_n = 1'b0;
        #1;
        model_reset();
        check("final_rst_halted", halted, 0);
        check("final_rst_illegal", illegal, 0);
        check("final_rst_ready", instr_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send(1, 2);
        finish_now();
    end

endmodule
